// File: rtl/llc_req_if.sv
// Request/issue bundle between the two LLC requesters, the arbiter and the LLC port.
// master = requesters plus LLC model side, slave = arbiter side.
interface llc_req_if #(
  parameter int CMDSIZE   = 4,
  parameter int ADDR_BITS = 32
);
  logic                 l1_valid;
  logic [CMDSIZE-1:0]   l1_cmd;
  logic [ADDR_BITS-1:0] l1_addr;
  logic                 l1_ready;
  logic                 snp_valid;
  logic [CMDSIZE-1:0]   snp_cmd;
  logic [ADDR_BITS-1:0] snp_addr;
  logic                 snp_ready;
  logic                 llc_cmd_valid;
  logic [CMDSIZE-1:0]   llc_cmd;
  logic [ADDR_BITS-1:0] llc_addr;
  logic                 llc_done;

  modport master (
    output l1_valid, l1_cmd, l1_addr, snp_valid, snp_cmd, snp_addr, llc_done,
    input  l1_ready, snp_ready, llc_cmd_valid, llc_cmd, llc_addr
  );

  modport slave (
    input  l1_valid, l1_cmd, l1_addr, snp_valid, snp_cmd, snp_addr, llc_done,
    output l1_ready, snp_ready, llc_cmd_valid, llc_cmd, llc_addr
  );
endinterface

// File: rtl/llc_req_arbiter.sv
// Arbitrates L1 and snoop requests onto the single LLC command port, with snoop
// priority bounded by a streak limit, illegal-command filtering and a done timeout.
module llc_req_arbiter #(
  parameter int CMDSIZE          = 4,
  parameter int ADDR_BITS        = 32,
  parameter int MAX_SNOOP_STREAK = 4,
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  llc_req_if.slave         bus,
  output logic             busy,
  output logic             illegal_cmd,
  output logic             timeout_err,
  output logic [CNT_W-1:0] l1_grants,
  output logic [CNT_W-1:0] snp_grants
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t               state, state_nx;
  logic [3:0]           streak, streak_nx;
  logic [TW-1:0]        tcnt, tcnt_nx;
  logic                 grant_snp, grant_l1, grant_any, sel_legal;
  logic                 illegal_nx, timeout_nx;
  logic                 src_snp;
  logic [CMDSIZE-1:0]   sel_cmd, cmd_q;
  logic [ADDR_BITS-1:0] sel_addr, addr_q;

  function automatic logic l1_legal(input logic [CMDSIZE-1:0] c);
    return (c == CMDSIZE'(0)) || (c == CMDSIZE'(1)) || (c == CMDSIZE'(2)) ||
           (c == CMDSIZE'(8)) || (c == CMDSIZE'(9));
  endfunction

  function automatic logic snp_legal(input logic [CMDSIZE-1:0] c);
    return (c == CMDSIZE'(3)) || (c == CMDSIZE'(4)) || (c == CMDSIZE'(5)) ||
           (c == CMDSIZE'(6));
  endfunction

  // Snoops win unless an L1 request has already waited out a full streak.
  assign grant_snp = (state == IDLE) && bus.snp_valid &&
                     (!bus.l1_valid || (streak < 4'(MAX_SNOOP_STREAK)));
  assign grant_l1  = (state == IDLE) && bus.l1_valid && !grant_snp;
  assign grant_any = grant_snp || grant_l1;
  assign sel_cmd   = grant_snp ? bus.snp_cmd  : bus.l1_cmd;
  assign sel_addr  = grant_snp ? bus.snp_addr : bus.l1_addr;
  assign sel_legal = grant_snp ? snp_legal(bus.snp_cmd) : l1_legal(bus.l1_cmd);

  assign bus.l1_ready      = grant_l1;
  assign bus.snp_ready     = grant_snp;
  assign bus.llc_cmd_valid = (state == ISSUE);
  assign bus.llc_cmd       = cmd_q;
  assign bus.llc_addr      = addr_q;
  assign busy              = (state != IDLE);

  always_comb begin
    state_nx   = state;
    streak_nx  = streak;
    tcnt_nx    = tcnt;
    illegal_nx = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          if (sel_legal) state_nx = ISSUE;
          else           illegal_nx = 1'b1;
        end
        if (grant_snp && bus.l1_valid)
          streak_nx = (streak >= 4'(MAX_SNOOP_STREAK)) ? streak : streak + 4'd1;
        else if (grant_any)
          streak_nx = 4'd0;
      end
      ISSUE: begin
        state_nx = WAIT_DONE;
        tcnt_nx  = '0;
      end
      WAIT_DONE: begin
        if (bus.llc_done) begin
          state_nx = IDLE;
          tcnt_nx  = '0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
          tcnt_nx    = '0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only legal grants overwrite the held command, so a dropped one leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      streak      <= 4'd0;
      tcnt        <= '0;
      illegal_cmd <= 1'b0;
      timeout_err <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      src_snp     <= 1'b0;
      l1_grants   <= '0;
      snp_grants  <= '0;
    end else begin
      state       <= state_nx;
      streak      <= streak_nx;
      tcnt        <= tcnt_nx;
      illegal_cmd <= illegal_nx;
      timeout_err <= timeout_nx;
      if (grant_any && sel_legal) begin
        cmd_q   <= sel_cmd;
        addr_q  <= sel_addr;
        src_snp <= grant_snp;
      end
      if (state == ISSUE) begin
        if (src_snp) snp_grants <= snp_grants + CNT_W'(1);
        else         l1_grants  <= l1_grants + CNT_W'(1);
      end
    end
  end

endmodule
